led_serializer: RTL and testbench

LED_SERIALIZER -- requirements
Module: led_serializer

---
 rtl/led_serializer.sv | 122 ++++++++++++
 tb/tb_led_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_serializer.sv
// Serialises pixel words onto an LED driver chain (clock/data/latch), latching after each full frame.
// Define LAMP_SER_LSB_FIRST_EN to shift each word LSB first instead of MSB first.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// st_idle     | o_ready high, waiting for i_valid; o_dai holds last bit
// st_shift_lo | serial clock low, current bit presented on o_dai
// st_shift_hi | serial clock high, o_dai unchanged (driver samples here)
// st_latch    | o_lat high for c_lat_cycles, then frame done
module led_serializer #(
  parameter int c_width      = 16,
  parameter int c_words      = 24,
  parameter int c_lat_cycles = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [c_width-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_clk,
  output logic               o_dai,
  output logic               o_lat,
  output logic               o_frame_done
);

  localparam logic [1:0] st_idle     = 2'd0;
  localparam logic [1:0] st_shift_lo = 2'd1;
  localparam logic [1:0] st_shift_hi = 2'd2;
  localparam logic [1:0] st_latch    = 2'd3;

  localparam int c_wc_w = (c_words > 1) ? $clog2(c_words) : 1;
  localparam int c_bc_w = (c_width > 1) ? $clog2(c_width) : 1;
  localparam int c_lc_w = (c_lat_cycles > 1) ? $clog2(c_lat_cycles) : 1;

  localparam logic [c_wc_w-1:0] c_last_word = c_wc_w'(c_words - 1);
  localparam logic [c_bc_w-1:0] c_last_bit  = c_bc_w'(c_width - 1);
  localparam logic [c_lc_w-1:0] c_last_lat  = c_lc_w'(c_lat_cycles - 1);

`ifdef LAMP_SER_LSB_FIRST_EN
  localparam int c_pos = 0;
`else
  localparam int c_pos = c_width - 1;
`endif

  logic [1:0]         state;
  logic [c_width-1:0] shreg;
  logic [c_width-1:0] shifted;
  logic [c_bc_w-1:0]  bit_cnt;
  logic [c_wc_w-1:0]  word_cnt;
  logic [c_lc_w-1:0]  lat_cnt;

  // The outgoing bit always sits at c_pos; shifting moves the next bit into it.
`ifdef LAMP_SER_LSB_FIRST_EN
  assign shifted = shreg >> 1;
`else
  assign shifted = shreg << 1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= st_idle;
      shreg        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      lat_cnt      <= '0;
      o_ready      <= 1'b0;
      o_clk        <= 1'b0;
      o_dai        <= 1'b0;
      o_lat        <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        st_idle: begin
          if (i_valid && o_ready) begin
            state   <= st_shift_lo;
            shreg   <= i_data;
            bit_cnt <= c_last_bit;
            o_dai   <= i_data[c_pos];
            o_ready <= 1'b0;
          end else begin
            o_ready <= 1'b1;
          end
        end
        st_shift_lo: begin
          state <= st_shift_hi;
          o_clk <= 1'b1;
        end
        st_shift_hi: begin
          o_clk <= 1'b0;
          if (bit_cnt != '0) begin
            state   <= st_shift_lo;
            bit_cnt <= bit_cnt - c_bc_w'(1);
            shreg   <= shifted;
            o_dai   <= shifted[c_pos];
          end else if (word_cnt == c_last_word) begin
            state   <= st_latch;
            o_lat   <= 1'b1;
            lat_cnt <= c_last_lat;
          end else begin
            state    <= st_idle;
            o_ready  <= 1'b1;
            word_cnt <= word_cnt + c_wc_w'(1);
          end
        end
        st_latch: begin
          if (lat_cnt == '0) begin
            state        <= st_idle;
            o_lat        <= 1'b0;
            o_ready      <= 1'b1;
            o_frame_done <= 1'b1;
            word_cnt     <= '0;
          end else begin
            lat_cnt <= lat_cnt - c_lc_w'(1);
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_serializer.sv
// Directed bench for led_serializer with c_width=16, c_words=2, c_lat_cycles=2.
// Expected bit order follows LAMP_SER_LSB_FIRST_EN when it is defined.
module tb_led_serializer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_ready, o_clk, o_dai, o_lat, o_frame_done;

  int checks = 0;
  int errors = 0;

  led_serializer #(.c_width(16), .c_words(2), .c_lat_cycles(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_clk(o_clk), .o_dai(o_dai), .o_lat(o_lat),
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled bit stream (first bit in the MSB) expected for word w.
  function automatic logic [15:0] ord(input logic [15:0] w);
    logic [15:0] r;
`ifdef LAMP_SER_LSB_FIRST_EN
    for (int i = 0; i < 16; i++) r[15-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic xfer(input logic [15:0] w, input bit hold, input bit scramble,
                      output logic [15:0] got, output int nbits, output int low,
                      output int waited);
    waited = 0;
    while (!o_ready && waited < 100) begin
      tick();
      waited++;
    end
    chk("ready_before_word", {31'd0, o_ready}, 32'd1);
    i_data  = w;
    i_valid = 1'b1;
    tick();
    if (!hold) i_valid = 1'b0;
    got = '0; nbits = 0; low = 0;
    while (!o_ready && !o_lat && low < 100) begin
      if (scramble) i_data = 16'($urandom);
      if (o_clk) begin
        got = {got[14:0], o_dai};
        nbits++;
      end
      low++;
      tick();
    end
  endtask

  task automatic latch_check(input string tag);
    int n;
    n = 0;
    while (o_lat && n < 10) begin
      chk({tag, "_lat_clk_low"}, {31'd0, o_clk}, 32'd0);
      n++;
      tick();
    end
    chk({tag, "_lat_len"}, n, 2);
    chk({tag, "_frame_done"}, {31'd0, o_frame_done}, 32'd1);
    chk({tag, "_ready_after_lat"}, {31'd0, o_ready}, 32'd1);
    tick();
    chk({tag, "_frame_done_pulse"}, {31'd0, o_frame_done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
    chk({tag, "_clk"}, {31'd0, o_clk}, 32'd0);
    chk({tag, "_dai"}, {31'd0, o_dai}, 32'd0);
    chk({tag, "_lat"}, {31'd0, o_lat}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, o_frame_done}, 32'd0);
  endtask

  initial begin
    logic [15:0] got, tmp;
    int nbits, low, waited, bad;

    i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    chk("ready_before_first_edge", {31'd0, o_ready}, 32'd0);
    tick();
    chk("ready_first_edge", {31'd0, o_ready}, 32'd1);

    // single word, frame not complete
    xfer(16'hA5C3, 1'b0, 1'b0, got, nbits, low, waited);
    chk("a5c3_bits", {16'd0, got}, {16'd0, ord(16'hA5C3)});
    chk("a5c3_nbits", nbits, 16);
    chk("a5c3_ready_low", low, 32);
    chk("a5c3_no_lat", {31'd0, o_lat}, 32'd0);
    chk("a5c3_ready_after", {31'd0, o_ready}, 32'd1);

    bad = 0;
    repeat (50) begin
      if (o_clk || !o_ready || o_lat) bad++;
      tick();
    end
    chk("idle_quiet", bad, 0);

    xfer(16'h1234, 1'b0, 1'b0, got, nbits, low, waited);
    chk("w1234_bits", {16'd0, got}, {16'd0, ord(16'h1234)});
    chk("w1234_ready_low", low, 32);
    chk("w1234_lat", {31'd0, o_lat}, 32'd1);
    latch_check("f1");

    // back-to-back with i_valid held high
    xfer(16'hFFFF, 1'b1, 1'b0, got, nbits, low, waited);
    chk("ffff_bits", {16'd0, got}, {16'd0, ord(16'hFFFF)});
    chk("ffff_ready_low", low, 32);
    chk("ffff_no_lat", {31'd0, o_lat}, 32'd0);
    xfer(16'h0001, 1'b0, 1'b0, got, nbits, low, waited);
    chk("b2b_gap", waited, 0);
    chk("w0001_bits", {16'd0, got}, {16'd0, ord(16'h0001)});
    chk("w0001_ready_low", low, 32);
    chk("w0001_lat", {31'd0, o_lat}, 32'd1);
    latch_check("f2");

    // i_data scrambled while shifting
    xfer(16'h3C96, 1'b0, 1'b1, got, nbits, low, waited);
    chk("scr1_bits", {16'd0, got}, {16'd0, ord(16'h3C96)});
    xfer(16'h8001, 1'b0, 1'b1, got, nbits, low, waited);
    chk("scr2_bits", {16'd0, got}, {16'd0, ord(16'h8001)});
    chk("scr2_lat", {31'd0, o_lat}, 32'd1);
    latch_check("f3");

    // reset in the middle of the second word
    xfer(16'h5555, 1'b0, 1'b0, got, nbits, low, waited);
    chk("w5555_no_lat", {31'd0, o_lat}, 32'd0);
    i_data = 16'hAAAA; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (17) tick();
    tmp = ord(16'hAAAA);
    chk("bit7_clk_high", {31'd0, o_clk}, 32'd1);
    chk("bit7_dai", {31'd0, o_dai}, {31'd0, tmp[7]});
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    xfer(16'h0F0F, 1'b0, 1'b0, got, nbits, low, waited);
    chk("post_rst_w1_bits", {16'd0, got}, {16'd0, ord(16'h0F0F)});
    chk("post_rst_w1_no_lat", {31'd0, o_lat}, 32'd0);
    xfer(16'hF00F, 1'b0, 1'b0, got, nbits, low, waited);
    chk("post_rst_w2_bits", {16'd0, got}, {16'd0, ord(16'hF00F)});
    chk("post_rst_w2_lat", {31'd0, o_lat}, 32'd1);
    latch_check("f4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
